// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: function codes, op width and FSM states.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_ANDN = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_ORN  = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(7);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the response consumer.
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic                req0_valid;
   logic                req0_ready;
   logic [ALU_OP_W-1:0] req0_op;
   logic [WIDTH-1:0]    req0_a;
   logic [WIDTH-1:0]    req0_b;

   logic                req1_valid;
   logic                req1_ready;
   logic [ALU_OP_W-1:0] req1_op;
   logic [WIDTH-1:0]    req1_a;
   logic [WIDTH-1:0]    req1_b;

   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_id;
   logic [WIDTH-1:0]    rsp_y;
   logic                rsp_zero;

   // Requesters plus response consumer
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_y, rsp_zero,
      output rsp_ready
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_y, rsp_zero,
      input  rsp_ready
   );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: logic, add/sub with wrap, signed set-less-than; unknown codes yield 0.
module alu_arbiter_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [ALU_OP_W-1:0] op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic [WIDTH-1:0]    y_c,
   output logic                zero_c
);

   always_comb begin
      y_c = '0;
      case (op)
         ALU_AND:  y_c = a & b;
         ALU_OR:   y_c = a | b;
         ALU_ADD:  y_c = a + b;
         ALU_XOR:  y_c = a ^ b;
         ALU_ANDN: y_c = a & ~b;
         ALU_ORN:  y_c = a | ~b;
         ALU_SUB:  y_c = a - b;
         ALU_SLT:  y_c = WIDTH'($signed(a) < $signed(b));
         default:  y_c = '0;
      endcase
      zero_c = (y_c == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a one-entry registered
// response slot, backpressure and a handed-off-response counter.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   alu_arbiter_if.slave     bus,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   state_t              state_q;
   state_t              state_d;
   logic                last_grant_q;
   logic                free_c;
   logic                grant_vld_c;
   logic                grant_id_c;

   logic [ALU_OP_W-1:0] alu_op_c;
   logic [WIDTH-1:0]    alu_a_c;
   logic [WIDTH-1:0]    alu_b_c;
   logic [WIDTH-1:0]    alu_y_c;
   logic                alu_zero_c;

   logic [WIDTH-1:0]    rsp_y_q;
   logic                rsp_zero_q;
   logic                rsp_id_q;
   logic [CNT_W-1:0]    ops_q;

   // Arbitration and next state; the slot is free when empty or being drained this cycle
   always_comb begin
      state_d     = state_q;
      free_c      = (state_q == ST_EMPTY) || bus.rsp_ready;
      grant_vld_c = 1'b0;
      grant_id_c  = 1'b0;

      if (free_c) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant_vld_c = 1'b1;
            grant_id_c  = ~last_grant_q;
         end else if (bus.req0_valid) begin
            grant_vld_c = 1'b1;
            grant_id_c  = 1'b0;
         end else if (bus.req1_valid) begin
            grant_vld_c = 1'b1;
            grant_id_c  = 1'b1;
         end
      end

      case (state_q)
         ST_EMPTY: if (grant_vld_c) state_d = ST_FULL;
         ST_FULL:  if (bus.rsp_ready && !grant_vld_c) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   assign alu_op_c = grant_id_c ? bus.req1_op : bus.req0_op;
   assign alu_a_c  = grant_id_c ? bus.req1_a  : bus.req0_a;
   assign alu_b_c  = grant_id_c ? bus.req1_b  : bus.req0_b;

   alu_arbiter_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op     (alu_op_c),
      .a      (alu_a_c),
      .b      (alu_b_c),
      .y_c    (alu_y_c),
      .zero_c (alu_zero_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         last_grant_q <= 1'b1;
         rsp_y_q      <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_id_q     <= 1'b0;
         ops_q        <= '0;
      end else begin
         state_q <= state_d;
         if (grant_vld_c) begin
            rsp_y_q      <= alu_y_c;
            rsp_zero_q   <= alu_zero_c;
            rsp_id_q     <= grant_id_c;
            last_grant_q <= grant_id_c;
         end
         if ((state_q == ST_FULL) && bus.rsp_ready) begin
            ops_q <= ops_q + CNT_W'(1);
         end
      end
   end

   assign bus.req0_ready = grant_vld_c && !grant_id_c;
   assign bus.req1_ready = grant_vld_c && grant_id_c;
   assign bus.rsp_valid  = (state_q == ST_FULL);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_y      = rsp_y_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign busy           = (state_q == ST_FULL);
   assign ops_done       = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 4;

   typedef struct packed {
      logic             r0;
      logic             r1;
      logic             vld;
      logic             id;
      logic [WIDTH-1:0] y;
      logic             zero;
      logic             busy;
      logic [CNT_W-1:0] cnt;
   } obs_t;

   logic             clk;
   logic             reset;
   logic             busy;
   logic [CNT_W-1:0] ops_done;

   alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

   alu_arbiter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .busy     (busy),
      .ops_done (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one held response (or none), who went last, responses handed off
   logic             m_pend;
   logic             m_id;
   logic [WIDTH-1:0] m_y;
   logic             m_zero;
   logic             m_last;
   int               m_cnt;

   function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return a ^ b;
         4'd4:    return a & ~b;
         4'd5:    return a | ~b;
         4'd6:    return a - b;
         4'd7:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      m_pend = 1'b0; m_id = 1'b0; m_y = '0; m_zero = 1'b0; m_last = 1'b1; m_cnt = 0;
   endtask

   task automatic model_grant(output logic gv, output logic gid);
      gv = 1'b0; gid = 1'b0;
      if (!m_pend || bus.rsp_ready) begin
         if (bus.req0_valid && bus.req1_valid) begin gv = 1'b1; gid = !m_last; end
         else if (bus.req0_valid) begin gv = 1'b1; gid = 1'b0; end
         else if (bus.req1_valid) begin gv = 1'b1; gid = 1'b1; end
      end
   endtask

   task automatic model_step();
      logic gv, gid;
      if (reset) begin
         model_reset();
      end else begin
         model_grant(gv, gid);
         if (m_pend && bus.rsp_ready) m_cnt++;
         if (gv) begin
            m_pend = 1'b1;
            m_id   = gid;
            m_last = gid;
            m_y    = gid ? alu_ref(bus.req1_op, bus.req1_a, bus.req1_b)
                         : alu_ref(bus.req0_op, bus.req0_a, bus.req0_b);
            m_zero = (m_y == '0);
         end else if (bus.rsp_ready) begin
            m_pend = 1'b0;
         end
      end
   endtask

   // One clock: drive, sample DUT and model expectation mid-cycle, then advance across the edge
   task automatic cyc(input logic v0, input logic [3:0] op0, input logic [WIDTH-1:0] a0,
                      input logic [WIDTH-1:0] b0, input logic v1, input logic [3:0] op1,
                      input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                      input logic rr, input logic rst, output obs_t o, output obs_t e);
      logic gv, gid;
      bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
      bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
      bus.rsp_ready  = rr;
      reset          = rst;
      #1;
      o.r0 = bus.req0_ready; o.r1 = bus.req1_ready; o.vld = bus.rsp_valid; o.id = bus.rsp_id;
      o.y = bus.rsp_y; o.zero = bus.rsp_zero; o.busy = busy; o.cnt = ops_done;
      model_grant(gv, gid);
      e.r0 = gv && !gid; e.r1 = gv && gid; e.vld = m_pend; e.id = m_id;
      e.y = m_y; e.zero = m_zero; e.busy = m_pend; e.cnt = CNT_W'(m_cnt);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      obs_t o, e;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, o, e);
   endtask

   task automatic test_reset();
      obs_t o, e;
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o, e);
      n_tests++;
      if (o !== obs_t'(0)) begin
         n_fail++; $display("FAIL reset_values: got %h want %h", o, obs_t'(0));
      end
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL reset_model: got %h want %h", o, e); end
   endtask

   task automatic test_single();
      obs_t o, e;
      do_reset();
      cyc(1, 4'd2, 32'd5, 32'hFFFF_FFF9, 0, 0, 0, 0, 1, 0, o, e);
      n_tests++;
      if (o.r0 !== 1'b1 || o.r1 !== 1'b0) begin
         n_fail++; $display("FAIL single_ready: got r0=%b r1=%b want r0=1 r1=0", o.r0, o.r1);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
      n_tests++;
      if (o.vld !== 1'b1 || o.id !== 1'b0 || o.y !== 32'hFFFF_FFFE || o.zero !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rsp: got v=%b id=%b y=%h z=%b want v=1 id=0 y=fffffffe z=0",
                  o.vld, o.id, o.y, o.zero);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
      n_tests++;
      if (o.cnt !== 4'd1 || o.vld !== 1'b0) begin
         n_fail++; $display("FAIL single_count: got cnt=%0d v=%b want cnt=1 v=0", o.cnt, o.vld);
      end
   endtask

   task automatic test_tie();
      obs_t o, e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc(1, 4'd0, 32'hA5A5_0F0F, 32'hFFFF_0000, 1, 4'd6, 32'd9, 32'd9, 1, 0, o, e);
         n_tests++;
         if (o.r0 !== ((i % 2) == 0) || o.r1 !== ((i % 2) == 1)) begin
            n_fail++; $display("FAIL tie_grant[%0d]: got r0=%b r1=%b", i, o.r0, o.r1);
         end
         if (i > 0 && (i % 2) == 0) begin
            n_tests++;
            if (o.vld !== 1'b1 || o.id !== 1'b1 || o.y !== '0 || o.zero !== 1'b1) begin
               n_fail++;
               $display("FAIL tie_rsp1[%0d]: got v=%b id=%b y=%h z=%b want v=1 id=1 y=0 z=1",
                        i, o.vld, o.id, o.y, o.zero);
            end
         end
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL tie_model[%0d]: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_backpressure();
      obs_t o, e;
      do_reset();
      cyc(1, 4'd2, 32'd3, 32'd4, 0, 0, 0, 0, 1, 0, o, e);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 1, 4'd3, 32'h0000_00F0, 32'h0000_000F, 0, 0, o, e);
         n_tests++;
         if (o.r0 !== 1'b0 || o.r1 !== 1'b0 || o.vld !== 1'b1 || o.id !== 1'b0 || o.y !== 32'd7) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got r1=%b v=%b id=%b y=%h want r1=0 v=1 id=0 y=7",
                     i, o.r1, o.vld, o.id, o.y);
         end
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL bp_model[%0d]: got %h want %h", i, o, e); end
      end
      cyc(0, 0, 0, 0, 1, 4'd3, 32'h0000_00F0, 32'h0000_000F, 1, 0, o, e);
      n_tests++;
      if (o.r1 !== 1'b1) begin n_fail++; $display("FAIL bp_release: got r1=%b want 1", o.r1); end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
      n_tests++;
      if (o.vld !== 1'b1 || o.id !== 1'b1 || o.y !== 32'h0000_00FF) begin
         n_fail++;
         $display("FAIL bp_rsp: got v=%b id=%b y=%h want v=1 id=1 y=ff", o.vld, o.id, o.y);
      end
   endtask

   task automatic test_opcodes();
      obs_t o, e;
      logic [3:0]       op_t [3] = '{4'd7, 4'd2, 4'd12};
      logic [WIDTH-1:0] a_t  [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
      logic [WIDTH-1:0] b_t  [3] = '{32'h0, 32'h1, 32'h0000_0001};
      logic [WIDTH-1:0] y_t  [3] = '{32'h1, 32'h8000_0000, 32'h0};
      for (int i = 0; i < 3; i++) begin
         cyc(1, op_t[i], a_t[i], b_t[i], 0, 0, 0, 0, 1, 0, o, e);
         cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
         n_tests++;
         if (o.vld !== 1'b1 || o.y !== y_t[i] || o.zero !== (y_t[i] == '0)) begin
            n_fail++;
            $display("FAIL opcode_edge[%0d]: got v=%b y=%h z=%b want y=%h", i, o.vld, o.y, o.zero, y_t[i]);
         end
      end
      for (int i = 0; i < 32; i++) begin
         cyc(1, 4'($urandom_range(0, 15)), $urandom, (i % 4 == 0) ? 32'h0 : $urandom,
             0, 0, 0, 0, 1, 0, o, e);
         cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL opcode_rand[%0d]: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_reset_full();
      obs_t o, e;
      cyc(0, 0, 0, 0, 1, 4'd1, 32'h11, 32'h22, 0, 0, o, e);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o, e);
      n_tests++;
      if (o.busy !== 1'b1 || o.vld !== 1'b1) begin
         n_fail++; $display("FAIL rf_pending: got busy=%b v=%b want 1 1", o.busy, o.vld);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, o, e);
      cyc(1, 4'd2, 32'd1, 32'd1, 1, 4'd2, 32'd2, 32'd2, 1, 0, o, e);
      n_tests++;
      if (o.vld !== 1'b0 || o.cnt !== '0 || o.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rf_cleared: got v=%b cnt=%0d busy=%b want 0 0 0", o.vld, o.cnt, o.busy);
      end
      n_tests++;
      if (o.r0 !== 1'b1 || o.r1 !== 1'b0) begin
         n_fail++; $display("FAIL rf_tie_port0: got r0=%b r1=%b want 1 0", o.r0, o.r1);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL rf_model: got %h want %h", o, e); end
   endtask

   task automatic test_wrap();
      obs_t o, e;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cyc(1, 4'($urandom_range(0, 7)), $urandom, $urandom, 0, 0, 0, 0, 1, 0, o, e);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
      n_tests++;
      if (o.cnt !== 4'd15 || o.vld !== 1'b1) begin
         n_fail++; $display("FAIL wrap_pre: got cnt=%0d v=%b want 15 1", o.cnt, o.vld);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, o, e);
      n_tests++;
      if (o.cnt !== 4'd0 || o.vld !== 1'b0) begin
         n_fail++; $display("FAIL wrap_zero: got cnt=%0d v=%b want 0 0", o.cnt, o.vld);
      end
   endtask

   // Random traffic; each requester holds its payload until accepted
   task automatic test_random();
      obs_t o, e;
      logic             hv0 = 0, hv1 = 0;
      logic [3:0]       hop0 = 0, hop1 = 0;
      logic [WIDTH-1:0] ha0 = 0, hb0 = 0, ha1 = 0, hb1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (!hv0 && $urandom_range(0, 2) != 0) begin
            hv0 = 1; hop0 = 4'($urandom_range(0, 15)); ha0 = $urandom;
            hb0 = ($urandom_range(0, 3) == 0) ? ha0 : $urandom;
         end
         if (!hv1 && $urandom_range(0, 2) != 0) begin
            hv1 = 1; hop1 = 4'($urandom_range(0, 15)); ha1 = $urandom;
            hb1 = ($urandom_range(0, 3) == 0) ? ha1 : $urandom;
         end
         cyc(hv0, hop0, ha0, hb0, hv1, hop1, ha1, hb1, 1'($urandom_range(0, 3) != 0), 0, o, e);
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, o, e); end
         if (e.r0) hv0 = 0;
         if (e.r1) hv1 = 0;
      end
   endtask

   initial begin
      bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
      bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
      bus.rsp_ready  = 0;
      reset          = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_opcodes();
      test_reset_full();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
